// File: rtl/breakout_pkg.sv
// Shared game-state encodings and VGA pixel bundle for the breakout
// screen path.
package breakout_pkg;

    typedef enum logic [1:0] {
        ST_MENU = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vga_t;

    localparam vga_t VGA_IDLE = '{
        hs: 1'b1, vs: 1'b1, r: 4'd0, g: 4'd0, b: 4'd0
    };

endpackage

// File: rtl/screen_select_if.sv
// Screen-source inputs (menu/play/game_over) and board VGA outputs
// of the screen mux.
interface screen_select_if;

    logic       M_HS, M_VS;
    logic [3:0] M_R, M_G, M_B;
    logic       P_HS, P_VS;
    logic [3:0] P_R, P_G, P_B;
    logic       G_HS, G_VS;
    logic [3:0] G_R, G_G, G_B;
    logic       VGA_HS, VGA_VS;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    modport master (
        output M_HS, M_VS, M_R, M_G, M_B,
        output P_HS, P_VS, P_R, P_G, P_B,
        output G_HS, G_VS, G_R, G_G, G_B,
        input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input  M_HS, M_VS, M_R, M_G, M_B,
        input  P_HS, P_VS, P_R, P_G, P_B,
        input  G_HS, G_VS, G_R, G_G, G_B,
        output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
    );

endinterface

// File: rtl/screen_select_debounce.sv
// Start-button path: 2-flop synchroniser, stability counter and
// single-cycle pulse on an accepted press.
module button_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          s1, s2, level;
    logic [CW-1:0] cnt;

    // cnt holds how many consecutive samples have disagreed with level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/screen_select.sv
// Game-state FSM and tear-free VGA source mux for breakout.
// Define SCREEN_BLANK_EN to black out RGB for a few frames after a switch.
module screen_select
    import breakout_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int OVER_SECONDS = 5,
    parameter int BLANK_FRAMES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       I_LOST,
    input  logic       I_WON,
    screen_select_if.slave vga,
    output logic [1:0] O_STATE,
    output logic       O_PLAY_RST
);

    localparam int TW = $clog2(CLK_HZ);
    localparam int SW = $clog2(OVER_SECONDS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(OVER_SECONDS - 1);

    state_t        state_q, state_d;
    logic          play_rst_q, play_rst_d;
    logic          start_p, tick, over_done;
    logic          enter_over, chg;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] sec_cnt;
    state_t        sel_q, target_q;
    logic          pending_q, swap, fall, vs_prev, blank;
    logic [2:0]    vs_q;
    vga_t          m_src, p_src, g_src, cur, out_q;

    button_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .CLK  (CLK),
        .RST  (RST),
        .btn  (BTN_START),
        .rise (start_p)
    );

    assign tick      = tick_cnt == TICK_LAST;
    assign over_done = tick && sec_cnt == SEC_LAST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_MENU;
            play_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            play_rst_q <= play_rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MENU: if (start_p) state_d = ST_PLAY;
            ST_PLAY: if (I_LOST || I_WON) state_d = ST_OVER;
            ST_OVER: if (start_p || over_done) state_d = ST_MENU;
            default: state_d = ST_MENU;
        endcase
    end

    always_comb begin
        play_rst_d = state_q == ST_MENU && start_p;
        enter_over = state_d == ST_OVER && state_q != ST_OVER;
        chg        = state_d != state_q;
        O_STATE    = state_q;
        O_PLAY_RST = play_rst_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
            sec_cnt  <= '0;
        end else if (enter_over) begin
            tick_cnt <= '0;
            sec_cnt  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (state_q == ST_OVER && tick)
                sec_cnt <= sec_cnt + SW'(1);
        end
    end

    assign m_src = {vga.M_HS, vga.M_VS, vga.M_R, vga.M_G, vga.M_B};
    assign p_src = {vga.P_HS, vga.P_VS, vga.P_R, vga.P_G, vga.P_B};
    assign g_src = {vga.G_HS, vga.G_VS, vga.G_R, vga.G_G, vga.G_B};

    always_comb begin
        cur     = m_src;
        vs_prev = vs_q[0];
        case (sel_q)
            ST_PLAY: begin
                cur     = p_src;
                vs_prev = vs_q[1];
            end
            ST_OVER: begin
                cur     = g_src;
                vs_prev = vs_q[2];
            end
            default: ;
        endcase
    end

    assign fall = vs_prev & ~cur.vs;
    assign swap = pending_q && fall && !chg;

    // a new state change always wins over a pending swap (last target wins)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel_q     <= ST_MENU;
            target_q  <= ST_MENU;
            pending_q <= 1'b0;
            vs_q      <= 3'b111;
        end else begin
            vs_q <= {vga.G_VS, vga.P_VS, vga.M_VS};
            if (chg) begin
                pending_q <= 1'b1;
                target_q  <= state_d;
            end else if (swap) begin
                sel_q     <= target_q;
                pending_q <= 1'b0;
            end
        end
    end

`ifdef SCREEN_BLANK_EN
    localparam int BW = $clog2(BLANK_FRAMES + 1);
    logic [BW-1:0] blank_cnt;

    // the switching edge itself counts as the first blank frame
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            blank_cnt <= '0;
        else if (swap)
            blank_cnt <= BW'(BLANK_FRAMES - 1);
        else if (blank_cnt != '0 && fall)
            blank_cnt <= blank_cnt - BW'(1);
    end

    assign blank = blank_cnt != '0;
`else
    logic [31:0] unused_blank_frames;
    assign unused_blank_frames = BLANK_FRAMES;
    assign blank = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q <= VGA_IDLE;
        end else begin
            out_q <= cur;
            if (blank) begin
                out_q.r <= '0;
                out_q.g <= '0;
                out_q.b <= '0;
            end
        end
    end

    assign vga.VGA_HS = out_q.hs;
    assign vga.VGA_VS = out_q.vs;
    assign vga.VGA_R  = out_q.r;
    assign vga.VGA_G  = out_q.g;
    assign vga.VGA_B  = out_q.b;

endmodule
